// File: rtl/relay_cpu_core.sv
// relay_cpu_core: small accumulator CPU with a serial program loader,
// two-word immediate/address instructions and single-step control.
module relay_cpu_core #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              loadValid,
  input  logic [DATA_W-1:0] loadData,
  input  logic              loadDone,
  input  logic              loadStart,
  input  logic              stepEn,
  input  logic              step,
  output logic              loadReady,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] regA,
  output logic [DATA_W-1:0] regB,
  output logic              flagZ,
  output logic              flagC,
  output logic [2:0]        state,
  output logic              halted,
  output logic              instrDone,
  output logic              memWrite
);

  typedef enum logic [2:0] {
    S_LOAD    = 3'd0,
    S_FETCH   = 3'd1,
    S_OPERAND = 3'd2,
    S_EXEC    = 3'd3,
    S_HALT    = 3'd4
  } state_e;

  localparam logic [3:0] OP_LDA   = 4'd1;
  localparam logic [3:0] OP_LDB   = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_AND   = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_LOAD  = 4'd7;
  localparam logic [3:0] OP_STORE = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JZ    = 4'd10;
  localparam logic [3:0] OP_JC    = 4'd11;
  localparam logic [3:0] OP_HALT  = 4'd15;

  function automatic logic [ADDR_W-1:0] inc_addr(
    input logic [ADDR_W-1:0] a
  );
    if (32'(a) >= 32'(MEM_DEPTH - 1)) return '0;
    return a + ADDR_W'(1);
  endfunction

  // operand addresses: truncate to ADDR_W, then fold into memory depth
  function automatic logic [ADDR_W-1:0] opr_addr(
    input logic [DATA_W-1:0] v
  );
    return ADDR_W'(32'(ADDR_W'(v)) % 32'(MEM_DEPTH));
  endfunction

  function automatic logic two_word(input logic [3:0] o);
    return o inside {OP_LDA, OP_LDB, OP_LOAD, OP_STORE,
                     OP_JMP, OP_JZ, OP_JC};
  endfunction

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] load_addr_q, load_addr_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] opr_q, opr_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              z_q, z_d;
  logic              c_q, c_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] fetch_word;
  logic [DATA_W-1:0] opr_word;
  logic [ADDR_W-1:0] opr_a;
  logic [3:0]        op;
  logic [DATA_W-1:0] alu_r;
  logic              alu_c;

  assign fetch_word = mem[pc_q];
  assign opr_a      = opr_addr(opr_q);
  assign opr_word   = mem[opr_a];
  assign op         = instr_q[3:0];

  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    unique case (op)
      OP_ADD:  {alu_c, alu_r} = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB:  {alu_c, alu_r} = {1'b0, a_q} - {1'b0, b_q};
      OP_AND:  alu_r = a_q & b_q;
      OP_XOR:  alu_r = a_q ^ b_q;
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    load_addr_d = load_addr_q;
    instr_d     = instr_q;
    opr_d       = opr_q;
    a_d         = a_q;
    b_d         = b_q;
    z_d         = z_q;
    c_d         = c_q;
    mem_we      = 1'b0;
    mem_waddr   = load_addr_q;
    mem_wdata   = loadData;
    unique case (state_q)
      S_LOAD: begin
        if (loadValid) begin
          mem_we      = 1'b1;
          load_addr_d = inc_addr(load_addr_q);
        end
        if (loadDone) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        if (!stepEn || step) begin
          instr_d = fetch_word;
          pc_d    = inc_addr(pc_q);
          state_d = two_word(fetch_word[3:0]) ? S_OPERAND : S_EXEC;
        end
      end
      S_OPERAND: begin
        opr_d   = fetch_word;
        pc_d    = inc_addr(pc_q);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        unique case (op)
          OP_LDA:  a_d = opr_q;
          OP_LDB:  b_d = opr_q;
          OP_ADD, OP_SUB, OP_AND, OP_XOR: begin
            a_d = alu_r;
            z_d = (alu_r == '0);
            c_d = alu_c;
          end
          OP_LOAD: a_d = opr_word;
          OP_STORE: begin
            mem_we    = 1'b1;
            mem_waddr = opr_a;
            mem_wdata = a_q;
          end
          OP_JMP:  pc_d = opr_a;
          OP_JZ:   if (z_q) pc_d = opr_a;
          OP_JC:   if (c_q) pc_d = opr_a;
          OP_HALT: state_d = S_HALT;
          default: ;
        endcase
      end
      S_HALT: begin
        if (loadStart) begin
          state_d     = S_LOAD;
          load_addr_d = '0;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_LOAD;
      pc_q        <= '0;
      load_addr_q <= '0;
      instr_q     <= '0;
      opr_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      load_addr_q <= load_addr_d;
      instr_q     <= instr_d;
      opr_q       <= opr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      z_q         <= z_d;
      c_q         <= c_d;
    end
  end

  // program memory survives reset
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign state     = state_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign regA      = a_q;
  assign regB      = b_q;
  assign flagZ     = z_q;
  assign flagC     = c_q;
  assign loadReady = (state_q == S_LOAD);
  assign halted    = (state_q == S_HALT);
  assign instrDone = (state_q == S_EXEC);
  assign memWrite  = (state_q == S_EXEC) && (op == OP_STORE);

endmodule

// File: tb/tb_relay_cpu_core.sv
// tb_relay_cpu_core: vector table, directed corner sequences and
// random programs checked against an instruction-level model.
module tb_relay_cpu_core;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int MD = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          loadValid = 1'b0;
  logic [DW-1:0] loadData = '0;
  logic          loadDone = 1'b0;
  logic          loadStart = 1'b0;
  logic          stepEn = 1'b0;
  logic          step = 1'b0;
  logic          loadReady;
  logic [AW-1:0] pc;
  logic [DW-1:0] instr;
  logic [DW-1:0] regA;
  logic [DW-1:0] regB;
  logic          flagZ;
  logic          flagC;
  logic [2:0]    state;
  logic          halted;
  logic          instrDone;
  logic          memWrite;

  relay_cpu_core #(
    .DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(MD)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .loadValid(loadValid), .loadData(loadData),
    .loadDone(loadDone), .loadStart(loadStart),
    .stepEn(stepEn), .step(step),
    .loadReady(loadReady), .pc(pc), .instr(instr),
    .regA(regA), .regB(regB),
    .flagZ(flagZ), .flagC(flagC), .state(state),
    .halted(halted), .instrDone(instrDone),
    .memWrite(memWrite)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [0:15][7:0] prog;
    int               n;
    logic [7:0]       a;
    logic [7:0]       b;
    logic             z;
    logic             c;
    int               pcv;
    int               cyc;
    int               ret;
    int               wr;
  } vec_t;

  vec_t vecs[10];

  logic [7:0] init_mem[16];
  logic [7:0] ref_mem[16];
  logic [7:0] m_a, m_b;
  logic       m_z, m_c, m_halt;
  int         m_pc, m_cyc, m_ret, m_wr;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string t);
    chk({t, ".state"}, int'(state), 0);
    chk({t, ".pc"}, int'(pc), 0);
    chk({t, ".instr"}, int'(instr), 0);
    chk({t, ".a"}, int'(regA), 0);
    chk({t, ".b"}, int'(regB), 0);
    chk({t, ".z"}, int'(flagZ), 0);
    chk({t, ".c"}, int'(flagC), 0);
    chk({t, ".halted"}, int'(halted), 0);
    chk({t, ".done"}, int'(instrDone), 0);
    chk({t, ".mw"}, int'(memWrite), 0);
    chk({t, ".ready"}, int'(loadReady), 1);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    loadValid = 1'b0;
    loadDone = 1'b0;
    loadStart = 1'b0;
    stepEn = 1'b0;
    step = 1'b0;
    #1 chk_reset("rst");
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  // last word carries loadDone in the same cycle
  task automatic load_prog(input logic [7:0] w[$]);
    foreach (w[i]) begin
      loadValid = 1'b1;
      loadData = w[i];
      loadDone = (i == w.size() - 1);
      @(posedge clock);
      #1;
    end
    loadValid = 1'b0;
    loadDone = 1'b0;
  endtask

  task automatic run(input int budget, output int cyc,
                     output int ret, output int wr);
    cyc = 0;
    ret = 0;
    wr = 0;
    while (!halted && cyc < budget) begin
      ret += int'(instrDone);
      wr += int'(memWrite);
      @(posedge clock);
      #1;
      cyc++;
    end
  endtask

  // instruction-level interpreter: 2 cycles per one-word op, 3 per two-word
  task automatic model_run(input int max_instr);
    int p;
    int opc;
    int s;
    logic [7:0] ins;
    logic [7:0] o;
    p = 0;
    o = '0;
    foreach (init_mem[j]) ref_mem[j] = init_mem[j];
    m_a = 0; m_b = 0; m_z = 0; m_c = 0; m_halt = 0;
    m_cyc = 0; m_ret = 0; m_wr = 0;
    for (int k = 0; k < max_instr && !m_halt; k++) begin
      ins = ref_mem[p];
      p = (p + 1) % 16;
      opc = int'(ins) % 16;
      m_cyc += 2;
      m_ret++;
      if (opc inside {[1:2], [7:11]}) begin
        o = ref_mem[p];
        p = (p + 1) % 16;
        m_cyc++;
      end
      case (opc)
        1: m_a = o;
        2: m_b = o;
        3: begin
          s = int'(m_a) + int'(m_b);
          m_c = (s > 255);
          m_a = 8'(s);
          m_z = (m_a == 0);
        end
        4: begin
          m_c = (m_a < m_b);
          m_a = 8'(int'(m_a) - int'(m_b));
          m_z = (m_a == 0);
        end
        5: begin m_a = m_a & m_b; m_c = 0; m_z = (m_a == 0); end
        6: begin m_a = m_a ^ m_b; m_c = 0; m_z = (m_a == 0); end
        7: m_a = ref_mem[int'(o) % 16];
        8: begin ref_mem[int'(o) % 16] = m_a; m_wr++; end
        9: p = int'(o) % 16;
        10: if (m_z) p = int'(o) % 16;
        11: if (m_c) p = int'(o) % 16;
        15: m_halt = 1;
        default: ;
      endcase
    end
    m_pc = p;
  endtask

  initial begin
    logic [7:0] q[$];
    int cyc, ret, wr, cnt, tries;

    vecs[0] = '{prog: {8'h01, 8'h05, 8'h02, 8'h03, 8'h03, 8'h0F,
                       {10{8'h00}}},
                n: 6, a: 8'h08, b: 8'h03, z: 0, c: 0,
                pcv: 6, cyc: 10, ret: 4, wr: 0};
    vecs[1] = '{prog: {8'h01, 8'h03, 8'h02, 8'h05, 8'h04, 8'h0F,
                       {10{8'h00}}},
                n: 6, a: 8'hFE, b: 8'h05, z: 0, c: 1,
                pcv: 6, cyc: 10, ret: 4, wr: 0};
    vecs[2] = '{prog: {8'h01, 8'h05, 8'h02, 8'h05, 8'h04, 8'h0F,
                       {10{8'h00}}},
                n: 6, a: 8'h00, b: 8'h05, z: 1, c: 0,
                pcv: 6, cyc: 10, ret: 4, wr: 0};
    vecs[3] = '{prog: {8'h01, 8'hFF, 8'h02, 8'h01, 8'h03, 8'h0F,
                       {10{8'h00}}},
                n: 6, a: 8'h00, b: 8'h01, z: 1, c: 1,
                pcv: 6, cyc: 10, ret: 4, wr: 0};
    vecs[4] = '{prog: {8'h01, 8'h5A, 8'h08, 8'h0E, 8'h01, 8'h00,
                       8'h07, 8'h0E, 8'h0F, {7{8'h00}}},
                n: 9, a: 8'h5A, b: 8'h00, z: 0, c: 0,
                pcv: 9, cyc: 14, ret: 5, wr: 1};
    vecs[5] = '{prog: {8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h0A,
                       8'h0A, 8'h01, 8'h11, 8'h0F, 8'h01, 8'h22,
                       8'h0F, {3{8'h00}}},
                n: 13, a: 8'h22, b: 8'h00, z: 1, c: 0,
                pcv: 13, cyc: 16, ret: 6, wr: 0};
    vecs[6] = '{prog: {8'h01, 8'h01, 8'h02, 8'h00, 8'h03, 8'h0A,
                       8'h0A, 8'h01, 8'h11, 8'h0F, 8'h01, 8'h22,
                       8'h0F, {3{8'h00}}},
                n: 13, a: 8'h11, b: 8'h00, z: 0, c: 0,
                pcv: 10, cyc: 16, ret: 6, wr: 0};
    vecs[7] = '{prog: {8'h01, 8'hF0, 8'h02, 8'h3C, 8'hA5, 8'h16,
                       8'hFF, {9{8'h00}}},
                n: 7, a: 8'h0C, b: 8'h3C, z: 0, c: 0,
                pcv: 7, cyc: 12, ret: 5, wr: 0};
    vecs[8] = '{prog: {8'h01, 8'h3C, 8'h02, 8'h3C, 8'h06, 8'h0F,
                       {10{8'h00}}},
                n: 6, a: 8'h00, b: 8'h3C, z: 1, c: 0,
                pcv: 6, cyc: 10, ret: 4, wr: 0};
    vecs[9] = '{prog: {8'h01, 8'hFF, 8'h02, 8'h02, 8'h03, 8'h0B,
                       8'h0A, 8'h01, 8'h11, 8'h0F, 8'h01, 8'h22,
                       8'h0F, {3{8'h00}}},
                n: 13, a: 8'h22, b: 8'h02, z: 0, c: 1,
                pcv: 13, cyc: 16, ret: 6, wr: 0};

    for (int i = 0; i < 10; i++) begin
      do_reset();
      q.delete();
      for (int j = 0; j < vecs[i].n; j++) q.push_back(vecs[i].prog[j]);
      load_prog(q);
      run(400, cyc, ret, wr);
      chk($sformatf("v%0d.halted", i), int'(halted), 1);
      chk($sformatf("v%0d.cyc", i), cyc, vecs[i].cyc);
      chk($sformatf("v%0d.ret", i), ret, vecs[i].ret);
      chk($sformatf("v%0d.wr", i), wr, vecs[i].wr);
      chk($sformatf("v%0d.a", i), int'(regA), int'(vecs[i].a));
      chk($sformatf("v%0d.b", i), int'(regB), int'(vecs[i].b));
      chk($sformatf("v%0d.z", i), int'(flagZ), int'(vecs[i].z));
      chk($sformatf("v%0d.c", i), int'(flagC), int'(vecs[i].c));
      chk($sformatf("v%0d.pc", i), int'(pc), vecs[i].pcv);
      chk($sformatf("v%0d.st", i), int'(state), 4);
      if (i == 4) chk("v4.mem14", int'(dut.mem[14]), 'h5A);
    end

    // HALT then loadStart: registers kept, loader restarts at 0
    loadValid = 1'b1;
    loadData = 8'h77;
    @(posedge clock);
    #1 loadValid = 1'b0;
    chk("hlt.ignore_load", int'(state), 4);
    loadStart = 1'b1;
    @(posedge clock);
    #1 loadStart = 1'b0;
    chk("ls.state", int'(state), 0);
    chk("ls.ready", int'(loadReady), 1);
    chk("ls.a", int'(regA), 'h22);
    chk("ls.c", int'(flagC), 1);
    q.delete();
    q.push_back(8'h0F);
    load_prog(q);
    run(50, cyc, ret, wr);
    chk("ls.halted", int'(halted), 1);
    chk("ls.cyc", cyc, 2);
    chk("ls.pc", int'(pc), 1);
    chk("ls.a2", int'(regA), 'h22);

    // all-NOP memory: pc walks through the wrap without stalling
    do_reset();
    q.delete();
    for (int j = 0; j < 16; j++) q.push_back(8'h00);
    load_prog(q);
    for (int k = 0; k < 18; k++) begin
      chk($sformatf("nop%0d.st", k), int'(state), 1);
      chk($sformatf("nop%0d.pc", k), int'(pc), k % 16);
      repeat (2) begin
        @(posedge clock);
        #1;
      end
    end

    // 17th loaded word wraps onto address 0
    do_reset();
    q.delete();
    for (int j = 0; j < 16; j++) q.push_back(8'(8'h20 + j));
    q.push_back(8'h0F);
    load_prog(q);
    run(50, cyc, ret, wr);
    chk("wrap.halted", int'(halted), 1);
    chk("wrap.cyc", cyc, 2);
    chk("wrap.pc", int'(pc), 1);
    chk("wrap.mem0", int'(dut.mem[0]), 'h0F);
    chk("wrap.mem1", int'(dut.mem[1]), 'h21);

    // single step
    do_reset();
    stepEn = 1'b1;
    q = '{8'h01, 8'h05, 8'h0F};
    load_prog(q);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("stall%0d.st", k), int'(state), 1);
      chk($sformatf("stall%0d.pc", k), int'(pc), 0);
      @(posedge clock);
      #1;
    end
    step = 1'b1;
    @(posedge clock);
    #1 step = 1'b0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      cnt += int'(instrDone);
      @(posedge clock);
      #1;
    end
    chk("step.ret", cnt, 1);
    chk("step.a", int'(regA), 5);
    chk("step.st", int'(state), 1);
    chk("step.pc", int'(pc), 2);
    stepEn = 1'b0;
    run(50, cyc, ret, wr);
    chk("step.halted", int'(halted), 1);

    // reset during OPERAND of STORE
    do_reset();
    q.delete();
    for (int j = 0; j < 16; j++) q.push_back(8'h00);
    q[0] = 8'h01; q[1] = 8'h5A; q[2] = 8'h08; q[3] = 8'h0E;
    q[4] = 8'h0F; q[14] = 8'h33;
    load_prog(q);
    repeat (4) begin
      @(posedge clock);
      #1;
    end
    chk("mid.st", int'(state), 2);
    reset_n = 1'b0;
    #1 chk_reset("mid");
    @(posedge clock);
    #1 reset_n = 1'b1;
    chk("mid.mem14", int'(dut.mem[14]), 'h33);

    // random programs against the instruction-level model
    for (int t = 0; t < 12; t++) begin
      tries = 0;
      do begin
        foreach (init_mem[j]) init_mem[j] = 8'($urandom);
        model_run(60);
        tries++;
      end while (!m_halt && tries < 50);
      if (!m_halt) begin
        init_mem[0] = 8'h0F;
        model_run(60);
      end
      do_reset();
      q.delete();
      foreach (init_mem[j]) q.push_back(init_mem[j]);
      load_prog(q);
      run(400, cyc, ret, wr);
      chk($sformatf("r%0d.halted", t), int'(halted), 1);
      chk($sformatf("r%0d.cyc", t), cyc, m_cyc);
      chk($sformatf("r%0d.ret", t), ret, m_ret);
      chk($sformatf("r%0d.wr", t), wr, m_wr);
      chk($sformatf("r%0d.a", t), int'(regA), int'(m_a));
      chk($sformatf("r%0d.b", t), int'(regB), int'(m_b));
      chk($sformatf("r%0d.z", t), int'(flagZ), int'(m_z));
      chk($sformatf("r%0d.c", t), int'(flagC), int'(m_c));
      chk($sformatf("r%0d.pc", t), int'(pc), m_pc);
      for (int j = 0; j < 16; j++)
        chk($sformatf("r%0d.mem%0d", t, j),
            int'(dut.mem[j]), int'(ref_mem[j]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
